// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the power-up / reset sequencer.
package rst_seq_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    HRAM_RESET  = 3'd2,
    HRAM_PWRUP  = 3'd3,
    CTRL_INIT   = 3'd4,
    CPU_DELAY   = 3'd5,
    RUN         = 3'd6,
    FAULT       = 3'd7
  } state_t;

  function automatic longint unsigned us_to_cycles(input longint unsigned freq_hz,
                                                   input longint unsigned us);
    return (freq_hz / 64'd1000000) * us;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// N-flop bit synchronizer, asynchronous active-low reset to 0.
module rst_seq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("rst_seq_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Qualifies PLL lock, then releases HyperRAM device, HyperRAM controller and CPU
// resets in order. Sole reset source for the clk_i domain.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ         = 54000000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned HRAM_RST_CYCLES     = 16,
  parameter int unsigned HRAM_PWRUP_US       = 150,
  parameter int unsigned INIT_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CPU_DELAY_CYCLES    = 16,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pll_lock_i,
  input  logic       hram_init_done_i,
  output logic       hram_rstn_o,
  output logic       hram_ctrl_rstn_o,
  output logic       cpu_rstn_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam longint unsigned PWRUP_CYCLES = us_to_cycles(CLK_FREQ_HZ, HRAM_PWRUP_US);
  localparam longint unsigned CNT_SPAN     = 64'd1 << CNT_W;

  if (LOCK_STABLE_CYCLES < 1 || longint'(LOCK_STABLE_CYCLES) > CNT_SPAN ||
      HRAM_RST_CYCLES < 1 || longint'(HRAM_RST_CYCLES) > CNT_SPAN ||
      PWRUP_CYCLES < 1 || PWRUP_CYCLES > CNT_SPAN ||
      INIT_TIMEOUT_CYCLES < 1 || longint'(INIT_TIMEOUT_CYCLES) > CNT_SPAN ||
      CPU_DELAY_CYCLES < 1 || longint'(CPU_DELAY_CYCLES) > CNT_SPAN) begin : g_bad_load
    $error("rst_sequencer: a counter load is outside 0 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LD_LOCK  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HRST  = CNT_W'(HRAM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(INIT_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_CPU   = CNT_W'(CPU_DELAY_CYCLES - 1);

  logic lock_s;

  rst_seq_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hram_rstn_d, ctrl_rstn_d, cpu_rstn_d, ready_d, fault_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      hram_rstn_o      <= 1'b0;
      hram_ctrl_rstn_o <= 1'b0;
      cpu_rstn_o       <= 1'b0;
      ready_o          <= 1'b0;
      fault_o          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      hram_rstn_o      <= hram_rstn_d;
      hram_ctrl_rstn_o <= ctrl_rstn_d;
      cpu_rstn_o       <= cpu_rstn_d;
      ready_o          <= ready_d;
      fault_o          <= fault_d;
    end
  end

  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = cnt_q;
        if (lock_s) begin
          state_d = LOCK_STABLE;
          cnt_d   = LD_LOCK;
        end
      end
      LOCK_STABLE: if (cnt_q == '0) begin
        state_d = HRAM_RESET;
        cnt_d   = LD_HRST;
      end
      HRAM_RESET: if (cnt_q == '0) begin
        state_d = HRAM_PWRUP;
        cnt_d   = LD_PWRUP;
      end
      HRAM_PWRUP: if (cnt_q == '0) begin
        state_d = CTRL_INIT;
        cnt_d   = LD_INIT;
      end
      CTRL_INIT: begin
        // init done takes priority over a coincident timeout
        if (hram_init_done_i) begin
          state_d = CPU_DELAY;
          cnt_d   = LD_CPU;
        end else if (cnt_q == '0) begin
          state_d = FAULT;
        end
      end
      CPU_DELAY: if (cnt_q == '0) state_d = RUN;
      RUN:       cnt_d = cnt_q;
      FAULT:     cnt_d = cnt_q;
    endcase

    // Lock loss overrides every sequencing state; FAULT only leaves on rstn_i
    if (!lock_s && state_q inside {LOCK_STABLE, HRAM_RESET, HRAM_PWRUP,
                                   CTRL_INIT, CPU_DELAY, RUN}) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end

    hram_rstn_d = state_d inside {HRAM_PWRUP, CTRL_INIT, CPU_DELAY, RUN, FAULT};
    ctrl_rstn_d = state_d inside {CTRL_INIT, CPU_DELAY, RUN};
    cpu_rstn_d  = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with reduced timing parameters.
module tb_rst_sequencer;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       pll_lock_i;
  logic       hram_init_done_i;
  logic       hram_rstn_o;
  logic       hram_ctrl_rstn_o;
  logic       cpu_rstn_o;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  rst_sequencer #(
    .CLK_FREQ_HZ         (54000000),
    .LOCK_STABLE_CYCLES  (8),
    .HRAM_RST_CYCLES     (4),
    .HRAM_PWRUP_US       (1),
    .INIT_TIMEOUT_CYCLES (100),
    .CPU_DELAY_CYCLES    (4),
    .SYNC_STAGES         (2)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .pll_lock_i       (pll_lock_i),
    .hram_init_done_i (hram_init_done_i),
    .hram_rstn_o      (hram_rstn_o),
    .hram_ctrl_rstn_o (hram_ctrl_rstn_o),
    .cpu_rstn_o       (cpu_rstn_o),
    .ready_o          (ready_o),
    .fault_o          (fault_o),
    .state_o          (state_o)
  );

  // Expected {hram_rstn, ctrl_rstn, cpu_rstn, ready, fault, state} for a state
  function automatic logic [7:0] exp_for(input logic [2:0] st);
    logic h, c, p, f;
    h = (st >= 3'd3);
    c = (st == 3'd4) || (st == 3'd5) || (st == 3'd6);
    p = (st == 3'd6);
    f = (st == 3'd7);
    return {h, c, p, p, f, st};
  endfunction

  task automatic chk(input string tag, input logic [2:0] st);
    logic [7:0] o, e;
    o = {hram_rstn_o, hram_ctrl_rstn_o, cpu_rstn_o, ready_o, fault_o, state_o};
    e = exp_for(st);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b (hram,ctrl,cpu,ready,fault,state)", tag, o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Starts just after LOCK_STABLE entry, ends just after CTRL_INIT entry
  task automatic seq_to_ctrl(input string tag);
    tick(7);  chk({tag, "_lock_stable_last"}, 3'd1);
    tick(1);  chk({tag, "_hram_reset_entry"}, 3'd2);
    tick(3);  chk({tag, "_hram_reset_last"}, 3'd2);
    tick(1);  chk({tag, "_pwrup_entry"}, 3'd3);
    tick(53); chk({tag, "_pwrup_last"}, 3'd3);
    tick(1);  chk({tag, "_ctrl_init_entry"}, 3'd4);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i           = 1'b0;
    pll_lock_i       = 1'b0;
    hram_init_done_i = 1'b0;
    tick(3);
    chk("reset", 3'd0);
    rstn_i = 1'b1;
    tick(5);
    chk("idle_no_lock", 3'd0);

    // Nominal run
    pll_lock_i = 1'b1;
    tick(2);  chk("sync_latency", 3'd0);
    tick(1);  chk("lock_stable_entry", 3'd1);
    seq_to_ctrl("nominal");
    tick(20); chk("ctrl_init_waiting", 3'd4);
    hram_init_done_i = 1'b1;
    tick(1);  chk("cpu_delay_entry", 3'd5);
    tick(3);  chk("cpu_delay_last", 3'd5);
    tick(1);  chk("run_entry", 3'd6);
    hram_init_done_i = 1'b0;
    tick(5);  chk("run_ignores_done", 3'd6);

    // Lock loss in RUN
    pll_lock_i = 1'b0;
    tick(2);  chk("run_lock_loss_2_edges", 3'd6);
    tick(1);  chk("run_lock_loss_3_edges", 3'd0);
    pll_lock_i = 1'b1;
    tick(3);  chk("relock_stable_entry", 3'd1);
    seq_to_ctrl("relock");

    // Init timeout
    tick(99); chk("timeout_last", 3'd4);
    tick(1);  chk("fault_entry", 3'd7);
    pll_lock_i = 1'b0;
    tick(6);  chk("fault_ignores_lock_low", 3'd7);
    pll_lock_i = 1'b1;
    tick(6);  chk("fault_ignores_lock_high", 3'd7);
    rstn_i = 1'b0;
    #2;       chk("fault_async_clear", 3'd0);
    tick(2);  chk("fault_reset_held", 3'd0);
    rstn_i = 1'b1;

    // Lock glitch during LOCK_STABLE
    tick(2);  chk("glitch_sync_latency", 3'd0);
    tick(1);  chk("glitch_stable_entry", 3'd1);
    tick(4);  chk("glitch_fifth_cycle", 3'd1);
    pll_lock_i = 1'b0;
    tick(1);
    pll_lock_i = 1'b1;
    tick(1);  chk("glitch_in_sync", 3'd1);
    tick(1);  chk("glitch_wait_lock", 3'd0);
    tick(1);  chk("glitch_restart", 3'd1);
    tick(7);  chk("glitch_stable_last", 3'd1);
    tick(1);  chk("glitch_hram_reset", 3'd2);
    tick(4);  chk("glitch_pwrup_entry", 3'd3);
    tick(10); chk("glitch_pwrup_mid", 3'd3);

    // Reset mid-sequence
    rstn_i = 1'b0;
    #2;       chk("pwrup_async_reset", 3'd0);
    tick(3);  chk("pwrup_reset_held", 3'd0);
    rstn_i = 1'b1;
    tick(2);  chk("restart_sync_latency", 3'd0);
    tick(1);  chk("restart_stable_entry", 3'd1);
    seq_to_ctrl("restart");

    // Init done coincident with timeout count reaching 0
    tick(99); chk("coincide_count_zero", 3'd4);
    hram_init_done_i = 1'b1;
    tick(1);  chk("coincide_cpu_delay", 3'd5);
    hram_init_done_i = 1'b0;
    tick(4);  chk("coincide_run", 3'd6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
